// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment codes, FSM states
// and the segment-to-hex decode function.
package seg7_pkg;

    typedef logic [6:0] seg_code_t;

    // Active-low segment codes, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
    localparam seg_code_t SEG_0     = 7'b0000001;
    localparam seg_code_t SEG_1     = 7'b1001111;
    localparam seg_code_t SEG_2     = 7'b0010010;
    localparam seg_code_t SEG_3     = 7'b0000110;
    localparam seg_code_t SEG_4     = 7'b1001100;
    localparam seg_code_t SEG_5     = 7'b0100100;
    localparam seg_code_t SEG_6     = 7'b0100000;
    localparam seg_code_t SEG_7     = 7'b0001111;
    localparam seg_code_t SEG_8     = 7'b0000000;
    localparam seg_code_t SEG_9     = 7'b0000100;
    localparam seg_code_t SEG_A     = 7'b0001000;
    localparam seg_code_t SEG_B     = 7'b1100000;
    localparam seg_code_t SEG_C     = 7'b0110001;
    localparam seg_code_t SEG_D     = 7'b1000010;
    localparam seg_code_t SEG_E     = 7'b0110000;
    localparam seg_code_t SEG_F     = 7'b0111000;
    localparam seg_code_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_hex(input seg_code_t code);
        seg_dec_t d;
        d = '0;
        case (code)
            SEG_0:     d.nibble = 4'h0;
            SEG_1:     d.nibble = 4'h1;
            SEG_2:     d.nibble = 4'h2;
            SEG_3:     d.nibble = 4'h3;
            SEG_4:     d.nibble = 4'h4;
            SEG_5:     d.nibble = 4'h5;
            SEG_6:     d.nibble = 4'h6;
            SEG_7:     d.nibble = 4'h7;
            SEG_8:     d.nibble = 4'h8;
            SEG_9:     d.nibble = 4'h9;
            SEG_A:     d.nibble = 4'hA;
            SEG_B:     d.nibble = 4'hB;
            SEG_C:     d.nibble = 4'hC;
            SEG_D:     d.nibble = 4'hD;
            SEG_E:     d.nibble = 4'hE;
            SEG_F:     d.nibble = 4'hF;
            SEG_BLANK: d.blank  = 1'b1;
            default:   d.err    = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_input_sync.sv
// Multi-bit flop-chain synchronizer; each bit is treated independently, the
// downstream stability filter absorbs any skew between bits.
module seg7_input_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: waits for a
// stable digit pattern, decodes it back to hex and stores it per digit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic [NDIG-1:0]                          i_anode_n,
    input  logic [6:0]                               i_seg_n,
    input  logic                                     i_clear,
    output logic [4*NDIG-1:0]                        o_digits,
    output logic [NDIG-1:0]                          o_digit_valid,
    output logic [NDIG-1:0]                          o_digit_blank,
    output logic [NDIG-1:0]                          o_code_err,
    output logic                                     o_update,
    output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] o_update_idx,
    output logic                                     o_frame_valid
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(STABLE_CYCLES + 1);
    localparam int SW   = NDIG + 7;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

    logic [SW-1:0]   w_sample;
    logic [NDIG-1:0] w_sa;
    seg_code_t       w_ss;
    logic            w_qual;
    logic            w_same;
    logic            w_capture;
    logic [IDXW-1:0] w_idx;
    seg_dec_t        w_dec;

    scan_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_sample;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0] r_digit_valid;
    logic [NDIG-1:0] r_digit_blank;
    logic [NDIG-1:0] r_code_err;
    logic            r_update;
    logic [IDXW-1:0] r_update_idx;
    logic            r_frame_valid;

    seg7_input_sync #(.W(SW), .STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({i_anode_n, i_seg_n}),
        .o_q     (w_sample)
    );

    assign w_sa   = w_sample[SW-1:7];
    assign w_ss   = w_sample[6:0];
    assign w_same = (w_sample == r_sample);
    assign w_dec  = seg_to_hex(w_ss);

    always_comb begin
        w_qual = ($countones(~w_sa) == 1);
        w_idx  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!w_sa[i]) w_idx = IDXW'(i);
        end
        // A stored sample is only ever loaded while qualified, so w_same implies a qualified anode.
        case (r_state)
            IDLE:    w_capture = w_qual && ONE_SHOT;
            SETTLE:  w_capture = w_same && (r_cnt >= CNT_LAST);
            HOLD:    w_capture = !w_same && w_qual && ONE_SHOT;
            default: w_capture = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sample      <= '0;
            r_digits      <= '0;
            r_digit_valid <= '0;
            r_digit_blank <= '0;
            r_code_err    <= '0;
            r_update      <= 1'b0;
            r_update_idx  <= '0;
            r_frame_valid <= 1'b0;
        end else if (i_clear) begin
            r_state       <= IDLE;
            r_digits      <= '0;
            r_digit_valid <= '0;
            r_digit_blank <= '0;
            r_code_err    <= '0;
            r_update      <= 1'b0;
            r_update_idx  <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_update      <= w_capture;
            r_frame_valid <= &r_digit_valid;
            if (w_capture) begin
                r_update_idx <= w_idx;
                if (w_dec.err) begin
                    r_code_err[w_idx] <= 1'b1;
                end else if (w_dec.blank) begin
                    r_digit_blank[w_idx] <= 1'b1;
                    r_digit_valid[w_idx] <= 1'b1;
                end else begin
                    r_digits[4*w_idx +: 4] <= w_dec.nibble;
                    r_digit_valid[w_idx]   <= 1'b1;
                    r_digit_blank[w_idx]   <= 1'b0;
                    r_code_err[w_idx]      <= 1'b0;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_qual) begin
                        r_sample <= w_sample;
                        r_cnt    <= CNT_ONE;
                        r_state  <= ONE_SHOT ? HOLD : SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_same) begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                        if (r_cnt >= CNT_LAST) r_state <= HOLD;
                    end else if (w_qual) begin
                        r_sample <= w_sample;
                        r_cnt    <= CNT_ONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!w_same) begin
                        if (w_qual) begin
                            r_sample <= w_sample;
                            r_cnt    <= CNT_ONE;
                            r_state  <= ONE_SHOT ? HOLD : SETTLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_digit_valid;
    assign o_digit_blank = r_digit_blank;
    assign o_code_err    = r_code_err;
    assign o_update      = r_update;
    assign o_update_idx  = r_update_idx;
    assign o_frame_valid = r_frame_valid;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random bus traffic, all
// checked against a run-length reference model of the display bus.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_anode_n;
    logic [6:0]  i_seg_n;
    logic        i_clear;
    logic [15:0] o_digits;
    logic [3:0]  o_digit_valid;
    logic [3:0]  o_digit_blank;
    logic [3:0]  o_code_err;
    logic        o_update;
    logic [1:0]  o_update_idx;
    logic        o_frame_valid;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_anode_n     (i_anode_n),
        .i_seg_n       (i_seg_n),
        .i_clear       (i_clear),
        .o_digits      (o_digits),
        .o_digit_valid (o_digit_valid),
        .o_digit_blank (o_digit_blank),
        .o_code_err    (o_code_err),
        .o_update      (o_update),
        .o_update_idx  (o_update_idx),
        .o_frame_valid (o_frame_valid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model: the decoder sees the raw bus SYNC edges late and captures
    // when a qualified pattern has been seen on exactly STABLE consecutive edges.
    logic [10:0] hist [$];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_valid, m_blank, m_err;
    logic        m_update, m_frame;
    logic [1:0]  m_idx;
    int          run;
    logic [10:0] prev;

    function automatic int zero_count(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_valid = '0; m_blank = '0; m_err = '0;
        m_update = 1'b0; m_frame = 1'b0; m_idx = '0;
        run = 0; prev = '0;
    endtask

    task automatic model_edge(input logic [3:0] an, input logic [6:0] sg, input logic clr);
        logic [10:0] v;
        logic [3:0]  old_valid;
        int          n, pos, hit;
        hist.push_back({an, sg});
        n = hist.size();
        v = (n - 1 - SYNC >= 0) ? hist[n-1-SYNC] : 11'h0;
        old_valid = m_valid;
        m_update = 1'b0;
        if (clr) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_valid = '0; m_blank = '0; m_err = '0; m_frame = 1'b0; m_idx = '0;
            run = 0;
        end else begin
            m_frame = &old_valid;
            if (zero_count(v[10:7]) == 1) begin
                if (run > 0 && v == prev) begin
                    if (run < 1000) run++;
                end else begin
                    run = 1;
                end
                if (run == STABLE) begin
                    pos = 0;
                    for (int i = 0; i < 4; i++) if (!v[7+i]) pos = i;
                    hit = -1;
                    for (int k = 0; k < 16; k++) if (codes[k] == v[6:0]) hit = k;
                    if (hit >= 0) begin
                        m_dig[pos] = 4'(hit);
                        m_valid[pos] = 1'b1; m_blank[pos] = 1'b0; m_err[pos] = 1'b0;
                    end else if (v[6:0] == 7'h7F) begin
                        m_blank[pos] = 1'b1; m_valid[pos] = 1'b1;
                    end else begin
                        m_err[pos] = 1'b1;
                    end
                    m_update = 1'b1;
                    m_idx = 2'(pos);
                end
            end else begin
                run = 0;
            end
        end
        prev = v;
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] sg, input logic clr);
        i_anode_n = an; i_seg_n = sg; i_clear = clr;
        @(posedge i_clk);
        model_edge(an, sg, clr);
        #1;
    endtask

    function automatic logic [31:0] exp_bundle();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_blank, m_err,
                m_update, (m_update ? m_idx : 2'b00), m_frame};
    endfunction

    function automatic logic [31:0] dut_bundle();
        return {o_digits, o_digit_valid, o_digit_blank, o_code_err,
                o_update, (o_update ? o_update_idx : 2'b00), o_frame_valid};
    endfunction

    task automatic test_reset();
        logic [31:0] got, exp;
        i_rst_n = 1'b0; i_anode_n = 4'hF; i_seg_n = 7'h7F; i_clear = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge i_clk);
            hist.push_back(11'h0);
        end
        #1;
        got = dut_bundle();
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL reset_state got %h exp %h", got, 32'h0);
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(4'hF, 7'h7F, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL reset_idle cyc %0d got %h exp %h", c, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] got, exp;
        int upd_at = -1, nupd = 0;
        logic [1:0] idx_seen = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            step(4'b1110, 7'b0000110, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL single cyc %0d got %h exp %h", c, got, exp);
            end
            if (o_update) begin upd_at = c; nupd++; idx_seen = o_update_idx; end
        end
        checks++;
        if (upd_at != 6 || nupd != 1) begin
            errors++; $display("FAIL single_latency got cyc %0d n %0d exp cyc 6 n 1", upd_at, nupd);
        end
        checks++;
        if (idx_seen !== 2'd0 || o_digits[3:0] !== 4'h3 || o_digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL single_value got idx %0d dig %h valid %b exp idx 0 dig 3 valid 0001",
                     idx_seen, o_digits[3:0], o_digit_valid);
        end
    endtask

    task automatic test_scan();
        logic [31:0] got, exp;
        logic [3:0] an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] sg [4] = '{7'b1001111, 7'b0001000, 7'b1100000, 7'b0111000};
        logic frm [32];
        int order [$];
        int last = -1, g = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 8; c++) begin
                step(an[d], sg[d], 1'b0);
                got = dut_bundle(); exp = exp_bundle();
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL scan cyc %0d got %h exp %h", g, got, exp);
                end
                frm[g] = o_frame_valid;
                if (o_update) begin order.push_back(int'(o_update_idx)); last = g; end
                g++;
            end
        end
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL scan_count got %0d exp 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != i) begin
                    errors++; $display("FAIL scan_order pos %0d got %0d exp %0d", i, order[i], i);
                end
            end
        end
        checks++;
        if (o_digits !== 16'hFBA1) begin
            errors++; $display("FAIL scan_digits got %h exp FBA1", o_digits);
        end
        checks++;
        if (last < 0 || last > 30) begin
            errors++; $display("FAIL scan_frame no final update got %0d exp 0..30", last);
        end else if (frm[last] !== 1'b0 || frm[last+1] !== 1'b1) begin
            errors++; $display("FAIL scan_frame got %b%b exp 01", frm[last], frm[last+1]);
        end
    endtask

    task automatic test_unstable();
        logic [31:0] got, exp;
        int nupd = 0;
        step(4'hF, 7'h7F, 1'b1);
        repeat (4) step(4'hF, 7'h7F, 1'b0);
        for (int c = 0; c < 24; c++) begin
            step(4'b1101, ((c / 2) % 2 == 0) ? 7'b0010010 : 7'b0100100, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL unstable cyc %0d got %h exp %h", c, got, exp);
            end
            if (o_update) nupd++;
        end
        checks++;
        if (nupd != 0 || o_digit_valid[1] !== 1'b0) begin
            errors++; $display("FAIL unstable_noupd got n %0d valid1 %b exp n 0 valid1 0", nupd, o_digit_valid[1]);
        end
    endtask

    task automatic test_blank_err();
        logic [31:0] got, exp;
        logic [6:0] pat [3] = '{7'b0100100, 7'b1111111, 7'b1010101};
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 8; c++) begin
                step(4'b1011, pat[p], 1'b0);
                got = dut_bundle(); exp = exp_bundle();
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL blank_err pat %0d cyc %0d got %h exp %h", p, c, got, exp);
                end
            end
            if (p == 1) begin
                checks++;
                if (o_digit_blank[2] !== 1'b1 || o_digit_valid[2] !== 1'b1 || o_digits[11:8] !== 4'h5) begin
                    errors++;
                    $display("FAIL blank got blank %b valid %b dig %h exp 1 1 5",
                             o_digit_blank[2], o_digit_valid[2], o_digits[11:8]);
                end
            end
        end
        checks++;
        if (o_code_err[2] !== 1'b1 || o_digits[11:8] !== 4'h5 || o_digit_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL code_err got err %b dig %h valid %b exp 1 5 1",
                     o_code_err[2], o_digits[11:8], o_digit_valid[2]);
        end
    endtask

    task automatic test_bad_anode();
        logic [31:0] got, exp;
        int nupd = 0;
        for (int c = 0; c < 20; c++) begin
            step((c < 10) ? 4'b1100 : 4'b1111, 7'b0000000, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL bad_anode cyc %0d got %h exp %h", c, got, exp);
            end
            if (o_update) nupd++;
        end
        checks++;
        if (nupd != 0) begin
            errors++; $display("FAIL bad_anode_noupd got %0d exp 0", nupd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        int upd_at = -1;
        for (int c = 1; c <= 5; c++) begin
            step(4'b0111, 7'b0001111, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL mid_settle cyc %0d got %h exp %h", c, got, exp);
            end
        end
        i_rst_n = 1'b0;
        #1;
        model_reset();
        got = dut_bundle();
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL mid_reset got %h exp %h", got, 32'h0);
        end
        repeat (2) begin
            @(posedge i_clk);
            hist.push_back(11'h0);
        end
        #1;
        i_rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step(4'b0111, 7'b0001111, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL post_reset cyc %0d got %h exp %h", c, got, exp);
            end
            if (o_update && upd_at < 0) upd_at = c;
        end
        checks++;
        if (upd_at != 6) begin
            errors++; $display("FAIL post_reset_latency got %0d exp 6", upd_at);
        end
        step(4'b1111, 7'b0001111, 1'b1);
        got = dut_bundle();
        checks++;
        if (got !== 32'h0) begin
            errors++; $display("FAIL hold_clear got %h exp %h", got, 32'h0);
        end
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 7'b0001111, 1'b0);
            got = dut_bundle(); exp = exp_bundle();
            checks++;
            if (got !== exp || o_update !== 1'b0) begin
                errors++; $display("FAIL after_clear cyc %0d got %h exp %h", c, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        logic [3:0] an;
        logic [6:0] sg;
        int hold, r, g = 0;
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 99));
            an = (r < 80) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 70)      sg = codes[$urandom_range(0, 15)];
            else if (r < 80) sg = 7'h7F;
            else             sg = 7'($urandom);
            hold = int'($urandom_range(1, 8));
            for (int c = 0; c < hold; c++) begin
                step(an, sg, (c == 0) && ($urandom_range(0, 24) == 0));
                got = dut_bundle(); exp = exp_bundle();
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL random cyc %0d got %h exp %h", g, got, exp);
                end
                g++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_unstable();
        test_blank_err();
        test_bad_anode();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side monitor for the multiplexed 7-segment display bus; the inverse of the hex-to-segment encoder.
- Samples the active-low anode and segment lines and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a 4-bit hex value and stores it per digit position.
- Used in self-check and loopback paths and as a capture front-end for the verification bench on board.

Parameters:
- NDIG, 4, number of multiplexed digits / anode lines.
- STABLE_CYCLES, 4, consecutive identical samples required before capture (range 1..255).
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (range 2..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- anode_n  in  NDIG  digit enables, active-low, one-hot-low when valid.
- seg_n  in  7  segments, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- clear  in  1  synchronous clear of all captured state.
- digits  out  4*NDIG  captured hex values; digit i is in bits [4i+3:4i].
- digit_valid  out  NDIG  digit i holds a captured value since reset/clear.
- digit_blank  out  NDIG  last capture on digit i was the all-off pattern.
- code_err  out  NDIG  last capture on digit i was an unknown pattern; sticky until next good capture or clear.
- update  out  1  one-cycle pulse on every capture.
- update_idx  out  $clog2(NDIG)  digit index for the current update pulse.
- frame_valid  out  1  all bits of digit_valid are set.

Behaviour:
- Reset value of every output is 0. FSM resets to IDLE. Counter and stored sample reset to 0.
- Synchronizer: anode_n and seg_n each pass through SYNC_STAGES flops. All logic below uses the synchronized values (sa, ss).
- Anode qualification: valid only when exactly one bit of sa is 0. All-ones or multiple zeros = no active digit.
- Decode table (ss -> nibble):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
  - 1111111=blank
  - any other pattern = error
- FSM states:
  - IDLE: no qualified anode. On a qualified anode: load the sample {sa,ss}, set cnt=1, go to SETTLE. If STABLE_CYCLES=1, capture immediately and go to HOLD.
  - SETTLE: if {sa,ss} equals the stored sample, cnt++. When cnt reaches STABLE_CYCLES, capture and go to HOLD. If the sample differs and the anode is qualified, reload the sample, set cnt=1, stay in SETTLE. If the anode is unqualified, go to IDLE.
  - HOLD: stay while the sample is unchanged; no repeated capture. On a change: go to SETTLE with cnt=1 if the anode is qualified, else go to IDLE.
- Capture, registered at the edge closing the STABLE_CYCLES-th identical sample, for active digit i:
  - Valid code: digits[i]=nibble, digit_valid[i]=1, digit_blank[i]=0, code_err[i]=0.
  - Blank: digit_blank[i]=1, digit_valid[i]=1, digits[i] unchanged.
  - Unknown pattern: code_err[i]=1, digits[i] unchanged, digit_valid[i] unchanged.
  - update=1 and update_idx=i for exactly that cycle.
- Latency: a raw input change held steady appears on the outputs SYNC_STAGES+STABLE_CYCLES clock edges later.
- Counter width is $clog2(STABLE_CYCLES+1); it saturates and never wraps.
- clear:
  - Zeroes digits, digit_valid, digit_blank, code_err, update, frame_valid.
  - Forces the FSM to IDLE.
  - Wins over a capture in the same cycle.
- frame_valid is registered: &digit_valid delayed by one cycle.
- Reset asserted mid-SETTLE aborts immediately with no partial capture. After release, capture needs the full synchronizer plus stability time again.
- A digit re-captured with the same value still pulses update.

Decomposition:
- Package seg7_pkg:
  - 7-bit segment code constants SEG_0..SEG_F and SEG_BLANK, with the bit-order note.
  - Typedef seg_code_t (logic [6:0]).
  - Enum scan_state_t {IDLE, SETTLE, HOLD}.
  - Decode function seg_to_hex returning {err, blank, nibble}.
- Sub-module: seg7_input_sync, a parameterized multi-bit synchronizer with async active-low reset.

Test Plan:
- Reset, then anode_n=1110 and seg_n=0000110 held 10 cycles -> update pulse 6 cycles after the change (STABLE_CYCLES=4, SYNC_STAGES=2), update_idx=0, digits[3:0]=3, digit_valid=0001.
- Scan 4 digits showing 1,A,b,F, 8 cycles each -> 4 updates in order; digits=16'hFbA1 with the digit-3 value in the top nibble; frame_valid high one cycle after the last update.
- Digit 1 pattern toggles every 2 cycles -> no update, digit_valid[1] stays 0.
- seg_n=1111111 on digit 2 -> digit_blank[2]=1, digit_valid[2]=1. Then seg_n=1010101 -> code_err[2]=1 and the digit value is unchanged.
- anode_n=1100 or 1111 with a valid segment code -> no update; FSM in IDLE.
- Assert rst_n low at cycle 3 of SETTLE, then clear while in HOLD -> all outputs 0, no spurious update.
